// File: rtl/panel_bus_sequencer.sv
// panel_bus_sequencer
//   Front-panel controller that shares one memory bus between a CPU and
//   the operator panel. While running (or single-stepping) the CPU bus is
//   passed straight through to memory; otherwise the panel owns the bus
//   and can examine/deposit memory, and it can pulse the CPU reset.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   cmd[7:0]              : one-cycle command pulses (bit0 RESET, 1 STOP,
//                           2 RUN, 3 STEP, 4 EXAMINE, 5 EXAMINE_NEXT,
//                           6 DEPOSIT, 7 DEPOSIT_NEXT)
//   sw_data               : address/data toggle switches (data in [7:0])
//   cpu_req/we/addr/wdata : CPU memory request, held until cpu_ack
//   cpu_ack/cpu_rdata     : CPU completion pulse and read data
//   mem_req/we/addr/wdata : memory request side
//   mem_ack/mem_rdata     : memory completion pulse and read data
//   cpu_reset             : CPU reset output
//   led_run/led_wait      : RUN and WAIT lamps
//   led_addr/led_data     : address and data lamps
module panel_bus_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int RST_CYC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        cmd,
  input  logic [ADDR_W-1:0] sw_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              cpu_reset,
  output logic              led_run,
  output logic              led_wait,
  output logic [ADDR_W-1:0] led_addr,
  output logic [7:0]        led_data
);

  localparam int CNT_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYC - 1);

  typedef enum logic [2:0] {
    ST_STOPPED,
    ST_RUNNING,
    ST_STEP,
    ST_P_RD,
    ST_P_WR,
    ST_P_RST
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_led_addr;
  logic [7:0]          r_led_data;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [7:0]          r_mem_wdata;
  logic                r_stop_pend;
  logic                r_rst_pend;
  logic [CNT_W-1:0]    r_rst_cnt;
  logic                r_led_run;
  logic                r_led_wait;
  logic                r_cpu_reset;

  // Keep only the lowest-numbered set command bit.
  logic [7:0] w_cmd_sel;
  logic [7:0] w_lower;
  assign w_lower[0] = 1'b0;
  for (genvar gi = 0; gi < 8; gi++) begin : g_cmd_pri
    assign w_cmd_sel[gi] = cmd[gi] & ~w_lower[gi];
    if (gi < 7) begin : g_chain
      assign w_lower[gi+1] = w_lower[gi] | cmd[gi];
    end
  end

  logic w_c_reset, w_c_stop, w_c_run, w_c_step;
  logic w_c_exam, w_c_exnext, w_c_dep, w_c_depnext;
  assign {w_c_depnext, w_c_dep, w_c_exnext, w_c_exam,
          w_c_step, w_c_run, w_c_stop, w_c_reset} = w_cmd_sel;

  logic w_pass;      // CPU bus routed to memory
  logic w_panel;     // panel-owned memory access in flight
  logic w_open;      // memory transaction outstanding after this cycle
  logic w_done;      // memory transaction completes this cycle
  logic w_rst_want;  // panel RESET requested now or earlier
  logic [ADDR_W-1:0] w_addr_tgt;

  assign w_pass     = (r_state == ST_RUNNING) || (r_state == ST_STEP);
  assign w_panel    = (r_state == ST_P_RD) || (r_state == ST_P_WR);
  assign w_open     = w_pass ? (cpu_req & ~mem_ack) : (w_panel & ~mem_ack);
  assign w_done     = w_pass ? (cpu_req & mem_ack) : (w_panel & mem_ack);
  assign w_rst_want = w_c_reset | r_rst_pend;
  assign w_addr_tgt = w_c_exam ? sw_data :
                      w_c_dep  ? r_led_addr : (r_led_addr + ADDR_W'(1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_STOPPED;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_STOPPED: begin
        if (w_c_reset)                    w_state_next = ST_P_RST;
        else if (w_c_run)                 w_state_next = ST_RUNNING;
        else if (w_c_step)                w_state_next = ST_STEP;
        else if (w_c_exam || w_c_exnext)  w_state_next = ST_P_RD;
        else if (w_c_dep || w_c_depnext)  w_state_next = ST_P_WR;
      end
      ST_RUNNING: begin
        if (w_rst_want) begin
          if (!w_open) w_state_next = ST_P_RST;
        end else if ((w_c_stop || r_stop_pend) && !w_open) begin
          w_state_next = ST_STOPPED;
        end
      end
      ST_STEP: begin
        if (w_rst_want) begin
          if (!w_open) w_state_next = ST_P_RST;
        end else if (w_done || (w_c_stop && !w_open)) begin
          w_state_next = ST_STOPPED;
        end
      end
      ST_P_RD, ST_P_WR: begin
        if (mem_ack) w_state_next = w_rst_want ? ST_P_RST : ST_STOPPED;
      end
      ST_P_RST: begin
        // A fresh RESET command restarts the hold window.
        if (!w_c_reset && (r_rst_cnt == '0)) w_state_next = ST_STOPPED;
      end
      default: w_state_next = ST_STOPPED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_led_addr  <= '0;
      r_led_data  <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_stop_pend <= 1'b0;
      r_rst_pend  <= 1'b0;
      r_rst_cnt   <= '0;
      r_led_run   <= 1'b0;
      r_led_wait  <= 1'b1;
      r_cpu_reset <= 1'b1;
    end else begin
      r_led_run   <= (w_state_next == ST_RUNNING);
      r_led_wait  <= !((w_state_next == ST_RUNNING) || (w_state_next == ST_STEP));
      r_cpu_reset <= (w_state_next == ST_P_RST);
      // STOP/RESET seen during an open transaction are remembered until it ends.
      r_stop_pend <= (r_state == ST_RUNNING) && (w_c_stop || r_stop_pend) && w_open;
      r_rst_pend  <= w_rst_want && w_open;

      if ((r_state == ST_STOPPED) &&
          ((w_state_next == ST_P_RD) || (w_state_next == ST_P_WR))) begin
        r_led_addr  <= w_addr_tgt;
        r_mem_addr  <= w_addr_tgt;
        r_mem_req   <= 1'b1;
        r_mem_we    <= (w_state_next == ST_P_WR);
        r_mem_wdata <= sw_data[7:0];
      end

      if (w_panel && mem_ack) begin
        r_mem_req  <= 1'b0;
        r_led_data <= r_mem_we ? r_mem_wdata : mem_rdata;
      end

      if (w_pass && w_done) begin
        r_led_addr <= cpu_addr;
        r_led_data <= cpu_we ? cpu_wdata : mem_rdata;
      end

      // Entering or staying in P_RST overrides any lamp capture above.
      if (w_state_next == ST_P_RST) begin
        if ((r_state != ST_P_RST) || w_c_reset) r_rst_cnt <= RST_LOAD;
        else                                    r_rst_cnt <= r_rst_cnt - CNT_W'(1);
        r_led_addr <= '0;
        r_led_data <= '0;
      end
    end
  end

  assign mem_req   = w_pass ? cpu_req   : r_mem_req;
  assign mem_we    = w_pass ? cpu_we    : r_mem_we;
  assign mem_addr  = w_pass ? cpu_addr  : r_mem_addr;
  assign mem_wdata = w_pass ? cpu_wdata : r_mem_wdata;
  assign cpu_ack   = w_pass ? mem_ack   : 1'b0;
  assign cpu_rdata = w_pass ? mem_rdata : 8'h00;
  assign cpu_reset = r_cpu_reset;
  assign led_run   = r_led_run;
  assign led_wait  = r_led_wait;
  assign led_addr  = r_led_addr;
  assign led_data  = r_led_data;

endmodule

// File: tb/tb_panel_bus_sequencer.sv
// Self-checking bench for panel_bus_sequencer: table of panel examine/deposit
// vectors plus hand-written sequences for run/stop/step/reset corners.
// A memory model pops expected transactions from a scoreboard queue.
module tb_panel_bus_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  cmd = 8'h00;
  logic [15:0] sw_data = 16'h0000;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic        cpu_reset;
  logic        led_run;
  logic        led_wait;
  logic [15:0] led_addr;
  logic [7:0]  led_data;

  panel_bus_sequencer #(.ADDR_W(16), .RST_CYC(4)) dut (
    .clk(clk), .reset(reset), .cmd(cmd), .sw_data(sw_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .cpu_reset(cpu_reset), .led_run(led_run), .led_wait(led_wait),
    .led_addr(led_addr), .led_data(led_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } txn_t;

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] sw;
    int          lat;
    logic [7:0]  rd;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  dat;
  } pvec_t;

  txn_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          mem_lat = 1;
  logic [7:0]  mem_rd = 8'h00;
  bit          m_busy = 1'b0;
  int          m_cnt = 0;
  bit          m_ack_now = 1'b0;
  int          m_req_cycles = 0;
  logic [15:0] m_addr_hold = 16'h0;
  logic        m_we_hold = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp_v);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic push_txn(input logic we, input logic [15:0] addr, input logic [7:0] wd);
    txn_t t;
    t.we = we;
    t.addr = addr;
    t.wdata = wd;
    exp_q.push_back(t);
  endtask

  // One clock: CPU drops its request after an acked edge, then the memory
  // model observes the bus and answers after mem_lat cycles of mem_req.
  task automatic tick();
    bit   cpu_done;
    txn_t t;
    cpu_done = cpu_req && cpu_ack;
    @(posedge clk);
    #1;
    if (cpu_done) cpu_req = 1'b0;
    #1;
    m_ack_now = 1'b0;
    mem_ack = 1'b0;
    if (reset) begin
      m_busy = 1'b0;
    end else if (mem_req) begin
      if (!m_busy) begin
        m_busy = 1'b1;
        m_cnt = 1;
        m_addr_hold = mem_addr;
        m_we_hold = mem_we;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL mem_txn_unexpected: got request addr %0h we %0b, required none", mem_addr, mem_we);
        end else begin
          t = exp_q.pop_front();
          chk("mem_we", 32'(mem_we), 32'(t.we));
          chk("mem_addr", 32'(mem_addr), 32'(t.addr));
          if (t.we) chk("mem_wdata", 32'(mem_wdata), 32'(t.wdata));
        end
      end else begin
        m_cnt++;
        chk("mem_addr_stable", 32'(mem_addr), 32'(m_addr_hold));
        chk("mem_we_stable", 32'(mem_we), 32'(m_we_hold));
      end
      if (m_cnt >= mem_lat) begin
        mem_ack = 1'b1;
        mem_rdata = mem_rd;
        m_ack_now = 1'b1;
        m_busy = 1'b0;
        m_req_cycles = m_cnt;
      end
    end else if (m_busy) begin
      chk("mem_req_held", 32'(mem_req), 32'd1);
      m_busy = 1'b0;
    end
    #1;
  endtask

  task automatic pulse(input logic [7:0] c);
    cmd = c;
    tick();
    cmd = 8'h00;
  endtask

  task automatic wait_mem_ack();
    int n = 0;
    while (!m_ack_now && n < 20) begin
      tick();
      n++;
    end
    chk("mem_ack_seen", 32'(m_ack_now), 32'd1);
  endtask

  task automatic wait_cpu_ack();
    int n = 0;
    while (!cpu_ack && n < 20) begin
      tick();
      n++;
    end
    chk("cpu_ack_seen", 32'(cpu_ack), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    pvec_t vecs[9];
    int    nrst;
    vecs[0] = '{8'h10, 16'h1234, 3, 8'hA5, 1'b0, 16'h1234, 8'hA5};
    vecs[1] = '{8'h20, 16'h0000, 1, 8'h5A, 1'b0, 16'h1235, 8'h5A};
    vecs[2] = '{8'h40, 16'h00C3, 2, 8'h00, 1'b1, 16'h1235, 8'hC3};
    vecs[3] = '{8'h80, 16'h0011, 1, 8'h00, 1'b1, 16'h1236, 8'h11};
    vecs[4] = '{8'h10, 16'hFFFF, 2, 8'h0F, 1'b0, 16'hFFFF, 8'h0F};
    vecs[5] = '{8'h80, 16'h003C, 1, 8'h00, 1'b1, 16'h0000, 8'h3C};
    vecs[6] = '{8'h20, 16'h0000, 4, 8'h99, 1'b0, 16'h0001, 8'h99};
    vecs[7] = '{8'h30, 16'h0ABC, 1, 8'h42, 1'b0, 16'h0ABC, 8'h42};
    vecs[8] = '{8'hC0, 16'h0077, 2, 8'h00, 1'b1, 16'h0ABC, 8'h77};

    // Reset state, then release.
    tick();
    tick();
    chk("rst_led_addr", 32'(led_addr), 32'h0);
    chk("rst_led_data", 32'(led_data), 32'h0);
    chk("rst_led_run", 32'(led_run), 32'd0);
    chk("rst_led_wait", 32'(led_wait), 32'd1);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    reset = 1'b0;
    tick();
    chk("rel_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("rel_led_wait", 32'(led_wait), 32'd1);

    // Panel examine/deposit table.
    foreach (vecs[i]) begin
      sw_data = vecs[i].sw;
      mem_lat = vecs[i].lat;
      mem_rd = vecs[i].rd;
      push_txn(vecs[i].we, vecs[i].addr, vecs[i].dat);
      pulse(vecs[i].cmd);
      wait_mem_ack();
      tick();
      chk("vec_led_addr", 32'(led_addr), 32'(vecs[i].addr));
      chk("vec_led_data", 32'(led_data), 32'(vecs[i].dat));
      chk("vec_led_wait", 32'(led_wait), 32'd1);
      chk("vec_led_run", 32'(led_run), 32'd0);
      chk("vec_mem_req_idle", 32'(mem_req), 32'd0);
      chk("vec_txn_consumed", 32'(exp_q.size()), 32'd0);
      if (i == 0) chk("vec_req_cycles", 32'(m_req_cycles), 32'd3);
    end

    // RUN+EXAMINE+EXAMINE_NEXT together: RUN wins, no panel read.
    pulse(8'h34);
    chk("multi_led_run", 32'(led_run), 32'd1);
    chk("multi_led_wait", 32'(led_wait), 32'd0);
    tick();
    chk("multi_no_read", 32'(mem_req), 32'd0);
    chk("multi_led_addr", 32'(led_addr), 32'h0ABC);

    // STOP while a CPU read is open: finish it, then stop.
    cpu_we = 1'b0;
    cpu_addr = 16'h0100;
    mem_lat = 3;
    mem_rd = 8'hB7;
    push_txn(1'b0, 16'h0100, 8'h00);
    cpu_req = 1'b1;
    tick();
    pulse(8'h02);
    chk("stop_still_run", 32'(led_run), 32'd1);
    wait_cpu_ack();
    chk("stop_cpu_rdata", 32'(cpu_rdata), 32'hB7);
    tick();
    chk("stop_led_run", 32'(led_run), 32'd0);
    chk("stop_led_wait", 32'(led_wait), 32'd1);
    chk("stop_led_addr", 32'(led_addr), 32'h0100);
    chk("stop_led_data", 32'(led_data), 32'hB7);
    cpu_addr = 16'h0300;
    cpu_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("stop_cpu_stall", 32'(cpu_ack), 32'd0);
      chk("stop_mem_idle", 32'(mem_req), 32'd0);
    end
    cpu_req = 1'b0;

    // RUN, CPU write, then STOP with nothing open.
    pulse(8'h04);
    chk("run2_led_run", 32'(led_run), 32'd1);
    cpu_we = 1'b1;
    cpu_addr = 16'h0400;
    cpu_wdata = 8'h55;
    mem_lat = 2;
    push_txn(1'b1, 16'h0400, 8'h55);
    cpu_req = 1'b1;
    wait_cpu_ack();
    tick();
    chk("run2_still_run", 32'(led_run), 32'd1);
    pulse(8'h02);
    chk("run2_stopped", 32'(led_run), 32'd0);
    chk("run2_led_wait", 32'(led_wait), 32'd1);
    chk("run2_led_addr", 32'(led_addr), 32'h0400);
    chk("run2_led_data", 32'(led_data), 32'h55);

    // STEP: one write passes, the next request stalls.
    pulse(8'h08);
    chk("step_led_wait", 32'(led_wait), 32'd0);
    chk("step_led_run", 32'(led_run), 32'd0);
    cpu_we = 1'b1;
    cpu_addr = 16'h0200;
    cpu_wdata = 8'h77;
    push_txn(1'b1, 16'h0200, 8'h77);
    cpu_req = 1'b1;
    wait_cpu_ack();
    tick();
    cpu_addr = 16'h0204;
    cpu_wdata = 8'h11;
    cpu_req = 1'b1;
    chk("step_done_wait", 32'(led_wait), 32'd1);
    chk("step_led_addr", 32'(led_addr), 32'h0200);
    chk("step_led_data", 32'(led_data), 32'h77);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("step_second_stall", 32'(cpu_ack), 32'd0);
      chk("step_mem_idle", 32'(mem_req), 32'd0);
    end
    cpu_req = 1'b0;
    cpu_we = 1'b0;

    // RUN and STOP during a panel read are ignored.
    sw_data = 16'h0042;
    mem_lat = 4;
    mem_rd = 8'h3E;
    push_txn(1'b0, 16'h0042, 8'h00);
    pulse(8'h10);
    pulse(8'h04);
    pulse(8'h02);
    wait_mem_ack();
    tick();
    chk("ign_led_run", 32'(led_run), 32'd0);
    chk("ign_led_wait", 32'(led_wait), 32'd1);
    chk("ign_led_data", 32'(led_data), 32'h3E);
    tick();
    chk("ign_no_queue", 32'(led_run), 32'd0);

    // RESET command during a panel read.
    sw_data = 16'h0050;
    mem_lat = 5;
    mem_rd = 8'hE1;
    push_txn(1'b0, 16'h0050, 8'h00);
    pulse(8'h10);
    tick();
    pulse(8'h01);
    chk("prst_wait_read", 32'(cpu_reset), 32'd0);
    wait_mem_ack();
    chk("prst_not_yet", 32'(cpu_reset), 32'd0);
    tick();
    chk("prst_led_addr", 32'(led_addr), 32'h0);
    chk("prst_led_data", 32'(led_data), 32'h0);
    nrst = 0;
    for (int k = 0; k < 10; k++) begin
      if (cpu_reset) nrst++;
      tick();
    end
    chk("prst_cycles", 32'(nrst), 32'd4);
    chk("prst_end_reset", 32'(cpu_reset), 32'd0);
    chk("prst_end_wait", 32'(led_wait), 32'd1);
    pulse(8'h04);
    chk("prst_then_run", 32'(led_run), 32'd1);
    pulse(8'h02);
    chk("prst_then_stop", 32'(led_run), 32'd0);

    // Load lamps, then hardware reset mid CPU transaction with RUN asserted.
    sw_data = 16'h0777;
    mem_lat = 1;
    mem_rd = 8'h5C;
    push_txn(1'b0, 16'h0777, 8'h00);
    pulse(8'h10);
    wait_mem_ack();
    tick();
    chk("hw_pre_led_data", 32'(led_data), 32'h5C);
    pulse(8'h04);
    cpu_we = 1'b0;
    cpu_addr = 16'h0500;
    mem_lat = 6;
    push_txn(1'b0, 16'h0500, 8'h00);
    cpu_req = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    cmd = 8'h04;
    tick();
    cmd = 8'h00;
    cpu_req = 1'b0;
    exp_q.delete();
    chk("hw_led_run", 32'(led_run), 32'd0);
    chk("hw_led_wait", 32'(led_wait), 32'd1);
    chk("hw_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("hw_mem_req", 32'(mem_req), 32'd0);
    chk("hw_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("hw_led_addr", 32'(led_addr), 32'h0);
    chk("hw_led_data", 32'(led_data), 32'h0);
    reset = 1'b0;
    tick();
    chk("hw_rel_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("hw_rel_led_run", 32'(led_run), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
